rvvi_ack_rx: RTL

RVVI_ACK_RX -- requirements
Module: rvvi_ack_rx

---
 rtl/rvvi_pkg.sv | 8 +
 rtl/flopenr.sv | 12 +
 rtl/rvvi_ack_rx.sv | 77 +++++++
 3 files changed

// File: rtl/rvvi_pkg.sv
// rvvi_pkg: shared FSM states and ack frame field constants for the rvvi ack receiver
package rvvi_pkg;
   typedef enum logic [2:0] {IDLE, DSTMAC, SRCMAC, ETYPE, PAYLOAD, PAD, DROP} state_t;
   localparam logic [15:0] ETHTYPE_DEF = 16'h88B5;
   localparam logic [3:0] MAC_LEN = 4'd6;
   localparam logic [3:0] ETYPE_LEN = 4'd2;
   localparam logic [3:0] PAYLOAD_LEN = 4'd12;
endpackage

// File: rtl/flopenr.sv
// flopenr: enabled register with synchronous active-high reset to zero
module flopenr #(parameter int W = 1) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (reset) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/rvvi_ack_rx.sv
// rvvi_ack_rx: parses ack frames from a byte stream into {Delay, Minstret} ack writes.
// Define RVVI_ACK_DSTMAC_FILTER_EN to drop frames not addressed to LocalMac or broadcast.
module rvvi_ack_rx import rvvi_pkg::*; #(
   parameter logic [15:0] ETHTYPE = ETHTYPE_DEF,
   parameter int          ACKW = 96
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RxValid,
   input  logic [7:0]      RxData,
   input  logic            RxLast,
   input  logic            RxError,
   input  logic [47:0]     LocalMac,
   output logic            AckValid,
   output logic [ACKW-1:0] AckData,
   output logic [15:0]     FrameCount,
   output logic [15:0]     DropCount
);
   logic [2:0]      state_q;
   state_t          state, nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic [ACKW-1:0] sr, sr_nxt;
   logic            ack, drop, dst_ok;
   assign state = state_t'(state_q);
   // EtherType bytes pass through the payload shifter; the 12 payload bytes flush them out
   assign sr_nxt = {sr[ACKW-9:0], RxData};
   always_comb begin
      nxt = state;
      ack = 1'b0;
      drop = 1'b0;
      if (RxValid) begin
         if (RxLast && RxError) begin
            nxt = IDLE;
            drop = 1'b1;
         end else begin
            case (state)
               IDLE:    if (RxLast) drop = 1'b1; else nxt = DSTMAC;
               DSTMAC:  if (RxLast) begin drop = 1'b1; nxt = IDLE; end
                        else if (cnt == MAC_LEN - 4'd1) nxt = dst_ok ? SRCMAC : DROP;
               SRCMAC:  if (RxLast) begin drop = 1'b1; nxt = IDLE; end
                        else if (cnt == MAC_LEN - 4'd1) nxt = ETYPE;
               ETYPE:   if (RxLast) begin drop = 1'b1; nxt = IDLE; end
                        else if (cnt == ETYPE_LEN - 4'd1) nxt = (sr_nxt[15:0] == ETHTYPE) ? PAYLOAD : DROP;
               PAYLOAD: if (cnt == PAYLOAD_LEN - 4'd1) begin ack = RxLast; nxt = RxLast ? IDLE : PAD; end
                        else if (RxLast) begin drop = 1'b1; nxt = IDLE; end
               PAD:     if (RxLast) begin ack = 1'b1; nxt = IDLE; end
               DROP:    if (RxLast) begin drop = 1'b1; nxt = IDLE; end
               default: nxt = IDLE;
            endcase
         end
      end
   end
   // the IDLE byte is dst byte 0, so DSTMAC starts counting at 1
   assign cnt_nxt = (state == IDLE && nxt == DSTMAC) ? 4'd1 : (nxt != state) ? 4'd0 : cnt + 4'd1;
`ifdef RVVI_ACK_DSTMAC_FILTER_EN
   logic [1:0] hit, hit_nxt;
   logic [2:0] idx;
   logic [7:0] mac_byte;
   assign idx = (state == IDLE) ? 3'd0 : cnt[2:0];
   assign mac_byte = LocalMac[47 - 8*idx -: 8];
   assign hit_nxt = {(state == IDLE || hit[1]) && RxData == mac_byte,
                     (state == IDLE || hit[0]) && RxData == 8'hFF};
   assign dst_ok = |hit_nxt;
   flopenr #(2) u_hit (.clk(clk), .reset(reset), .en(RxValid && (state == IDLE || state == DSTMAC)), .d(hit_nxt), .q(hit));
`else
   logic unused_mac;
   assign unused_mac = ^LocalMac;
   assign dst_ok = 1'b1;
`endif
   flopenr #(3)    u_state (.clk(clk), .reset(reset), .en(RxValid), .d(nxt), .q(state_q));
   flopenr #(4)    u_cnt   (.clk(clk), .reset(reset), .en(RxValid), .d(cnt_nxt), .q(cnt));
   flopenr #(ACKW) u_sr    (.clk(clk), .reset(reset), .en(RxValid && (state == ETYPE || state == PAYLOAD)), .d(sr_nxt), .q(sr));
   flopenr #(ACKW) u_data  (.clk(clk), .reset(reset), .en(ack), .d(state == PAYLOAD ? sr_nxt : sr), .q(AckData));
   flopenr #(1)    u_valid (.clk(clk), .reset(reset), .en(1'b1), .d(ack), .q(AckValid));
   flopenr #(16)   u_fc    (.clk(clk), .reset(reset), .en(ack && FrameCount != 16'hFFFF), .d(FrameCount + 16'd1), .q(FrameCount));
   flopenr #(16)   u_dc    (.clk(clk), .reset(reset), .en(drop && DropCount != 16'hFFFF), .d(DropCount + 16'd1), .q(DropCount));
endmodule
